pio_input_debounce: RTL and testbench
=====================================

# pio_input_debounce

Multi-channel input conditioner that sits directly upstream of the 8-bit Avalon PIO input port. It takes raw asynchronous board inputs (push-buttons, DIP switches), synchronises them into `clk`, debounces each bit independently and drives a clean, glitch-free bus into the PIO `in_port`. Per-bit one-cycle rise/fall strobes are also produced for interrupt or edge-capture logic.

## Interface
- `WIDTH`, 8: number of channels; matches the PIO input width.
- `SYNC_STAGES`, 2: synchroniser flops per channel; legal range ≥2.
- `DEBOUNCE_CYCLES`, 50000: consecutive cycles a new level must persist before it is accepted (1 ms at 50 MHz); legal range ≥1.
- `RESET_VALUE`, {WIDTH{1'b0}}: reset level of synchroniser chain and debounced output.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `raw_in`  in  WIDTH  asynchronous raw inputs.
- `debounced`  out  WIDTH  clean level, connects to PIO `in_port`.
- `rise`  out  WIDTH  one-cycle strobe, bit accepted 0→1.
- `fall`  out  WIDTH  one-cycle strobe, bit accepted 1→0.
- `changed`  out  1  OR of all `rise|fall` bits, same cycle.

## Operation
- Per channel: `SYNC_STAGES`-deep flop chain; last stage is `s`.
- Counter width `CNT_W = max(1, clog2(DEBOUNCE_CYCLES))`; one counter per channel.
- Two-state machine per channel: STABLE (`s == debounced`) and PENDING (`s != debounced`); state is implied by the comparison, with no extra state flop.
- Each edge, per channel:
  - `s == debounced`: `cnt <= 0`. This covers a glitch ending and discards partial counts.
  - `s != debounced` and `cnt == DEBOUNCE_CYCLES-1`: `debounced <= s`, `cnt <= 0`, assert `rise` or `fall` according to new value.
  - otherwise: `cnt <= cnt + 1`.
- `rise`, `fall` and `changed` are registered, high for exactly one cycle, and coincide with the `debounced` update.
- Channels are fully independent. Simultaneous acceptance on several bits gives several strobe bits in the same cycle, with `changed` high once.
- `DEBOUNCE_CYCLES == 1`: any synchronised change is accepted on the first cycle it is seen (pure synchroniser).
- Counter never wraps; the maximum value reached is `DEBOUNCE_CYCLES-1`.
- Reset values: synchroniser flops and `debounced` = `RESET_VALUE`; `cnt` = 0; `rise`, `fall` and `changed` = 0. Because the chain resets to `RESET_VALUE`, release of reset produces no spurious strobe.
- Reset asserted mid-count: everything returns immediately to reset values and the pending count is lost.

## Timing
- Raw change sampled at edge E appears at `s` after edge E+SYNC_STAGES-1.
- If held, `debounced` and the strobe update at edge E+SYNC_STAGES-1+DEBOUNCE_CYCLES. With defaults this is E+50001.
- Any bounce that returns `s` to `debounced` before the count completes restarts the count from 0. The pulse must then persist for `DEBOUNCE_CYCLES` cycles again.
- The minimum accepted pulse is `DEBOUNCE_CYCLES` cycles at `s`; anything shorter is filtered with no output activity.
- After an accept, a reverse transition needs a further full `DEBOUNCE_CYCLES`. The minimum spacing between strobes on one bit is `DEBOUNCE_CYCLES` cycles.
- No combinational path from `raw_in` to any output.

## Structure
- Shared package `pio_debounce_pkg` holds:
  - the default constants (`DEBOUNCE_CYCLES_1MS_50MHZ = 50000`, default `SYNC_STAGES = 2`);
  - the `CNT_W` computation function, so PIO wrappers and testbenches derive identical widths.
- One sub-module, `pio_debounce_chan`: single-bit synchroniser, counter and accept logic with `rise`/`fall` outputs.
- The top instantiates `pio_debounce_chan` `WIDTH` times in a generate loop and ORs the strobes into `changed`.

## Test plan
All scenarios use `WIDTH=8`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`, `RESET_VALUE=8'h00`.
- Reset release with `raw_in=8'h00` → `debounced=8'h00`, no strobes for 20 cycles. With `raw_in=8'hFF` during reset, expect `rise=8'hFF` exactly once, 5 cycles after release.
- `raw_in[0]` 0→1 at edge 10 and held → `debounced[0]=1`, `rise[0]=1` and `changed=1` at edge 15 only. All other bits stay 0.
- `raw_in[3]` high for 3 cycles, then low → no change on `debounced`, `rise` or `changed`. Repeat as a bounce train 1,0,1,1,0 followed by a steady 1 → single `rise[3]`, 4 cycles after the last 0→1 reaches `s`.
- `raw_in` 8'h00→8'hA5 at the same edge → `rise=8'hA5`, `debounced=8'hA5` in the same cycle, `changed` high one cycle. Then 8'hA5→8'h00 → `fall=8'hA5`.
- Assert `reset_n` while bit 2 count is at 2 → `debounced[2]` stays 0 and `cnt` reads 0. After release with input still high → `rise[2]` after a full 5-cycle latency.
- Randomised bounce on all 8 bits for 10k cycles, checked against a reference model: no strobe closer than 4 cycles on any bit, and `debounced` always equals the model.

Source files
------------

// File: rtl/pio_debounce_pkg.sv
// Shared constants and width helper for the PIO input debouncer.
// Wrappers and testbenches import this package so that every user derives the
// same counter width from the same debounce length.
package pio_debounce_pkg;

  // 1 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_1MS_50MHZ = 50000;
  localparam int unsigned SYNC_STAGES_DEFAULT       = 2;

  // Counter width for a given debounce length.
  // It holds values up to cycles-1 and is never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pio_debounce_chan.sv
// Single-channel conditioner: synchroniser chain, persistence counter and accept
// logic.
//   clk, reset_n  : system clock and asynchronous active-low reset
//   raw_in        : asynchronous raw input bit
//   debounced     : accepted level
//   rise, fall    : registered one-cycle strobes, coincident with a debounced update
//   accept_next   : next-state accept flag, so the parent can register a combined strobe
module pio_debounce_chan
  import pio_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_1MS_50MHZ,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic accept_next
);

  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // STABLE vs PENDING is implied by s == deb_q; there is no separate state flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == deb_q) begin
      // A glitch that returns to the accepted level discards any partial count.
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      deb_d  = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q  <= '0;
      deb_q  <= RESET_VALUE;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign debounced   = deb_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign accept_next = rise_d | fall_d;

endmodule

// File: rtl/pio_input_debounce.sv
// Multi-channel input conditioner feeding the Avalon PIO in_port.
// Each bit is synchronised and debounced independently.
//   clk, reset_n : system clock and asynchronous active-low reset
//   raw_in       : asynchronous board inputs
//   debounced    : clean level for the PIO in_port
//   rise, fall   : per-bit one-cycle accept strobes
//   changed      : registered OR of all rise/fall bits, aligned with them
module pio_input_debounce
  import pio_debounce_pkg::*;
#(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned      DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_1MS_50MHZ,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] accept;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pio_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE    (RESET_VALUE[i])
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw_in     (raw_in[i]),
      .debounced  (debounced[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .accept_next(accept[i])
    );
  end

  // Built from the channels' next-state accepts so changed is a flop aligned with rise/fall.
  always_comb begin
    changed_d = |accept;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_pio_input_debounce.sv
// Self-checking bench for pio_input_debounce (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A behavioural model checks every cycle: a bit is accepted once its synchronised value
// has disagreed with the accepted level for the last DEBOUNCE_CYCLES edges.
// Directed scenarios add literal expectations.
module tb_pio_input_debounce;
  import pio_debounce_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam logic [W-1:0] RV = 8'h00;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] debounced, rise, fall;
  logic         changed;

  int n_total = 0;
  int n_pass  = 0;
  int strobe_events = 0;
  int cyc = 0;

  pio_input_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_VALUE    (RV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_in   (raw_in),
    .debounced(debounced),
    .rise     (rise),
    .fall     (fall),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] raw_hist[$];  // last SS raw samples, oldest first
  logic [W-1:0] s_hist[$];    // last DC pre-edge synchronised values
  logic [W-1:0] deb_m, rise_m, fall_m;
  logic         chg_m;
  int           last_strobe[W];

  task automatic model_reset();
    raw_hist.delete();
    for (int i = 0; i < int'(SS); i++) raw_hist.push_back(RV);
    s_hist.delete();
    deb_m  = RV;
    rise_m = '0;
    fall_m = '0;
    chg_m  = 1'b0;
    for (int b = 0; b < int'(W); b++) last_strobe[b] = -1;
  endtask

  task automatic model_step();
    logic [W-1:0] s_pre, acc;
    bit all_diff;
    s_pre = raw_hist.pop_front();
    raw_hist.push_back(raw_in);
    s_hist.push_back(s_pre);
    if (s_hist.size() > int'(DC)) s_hist.delete(0);
    acc = '0;
    if (s_hist.size() == int'(DC)) begin
      for (int b = 0; b < int'(W); b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < int'(DC); j++) if (s_hist[j][b] == deb_m[b]) all_diff = 1'b0;
        acc[b] = all_diff;
      end
    end
    rise_m = acc & s_pre;
    fall_m = acc & ~s_pre;
    chg_m  = |acc;
    deb_m  = (deb_m & ~acc) | (s_pre & acc);
  endtask

  // Model update on each edge, compare 1 time unit later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) model_reset();
      else model_step();
      #1;
      chk("debounced", 32'(debounced), 32'(deb_m));
      chk("rise", 32'(rise), 32'(rise_m));
      chk("fall", 32'(fall), 32'(fall_m));
      chk("changed", 32'(changed), 32'(chg_m));
      if ((rise | fall) != '0 || changed) strobe_events++;
      for (int b = 0; b < int'(W); b++) begin
        if (rise[b] || fall[b]) begin
          if (last_strobe[b] >= 0)
            chk($sformatf("strobe_spacing_ge_%0d_bit%0d", DC, b),
                32'((cyc - last_strobe[b]) >= int'(DC)), 32'd1);
          last_strobe[b] = cyc;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    raw_in = v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int ev0;

  initial begin
    // Reset with quiet inputs.
    tick(3);
    chk("reset_debounced", 32'(debounced), 32'h00);
    chk("reset_rise", 32'(rise), 32'h00);
    chk("reset_fall", 32'(fall), 32'h00);
    chk("reset_changed", 32'(changed), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    ev0 = strobe_events;
    tick(20);
    chk("quiet_release_strobes", 32'(strobe_events - ev0), 32'd0);
    chk("quiet_release_debounced", 32'(debounced), 32'h00);

    // Single bit held: accept 5 edges after the first sampling edge.
    drive(8'h01);
    tick(5);
    chk("bit0_before_accept_deb", 32'(debounced), 32'h00);
    chk("bit0_before_accept_rise", 32'(rise), 32'h00);
    tick(1);
    chk("bit0_accept_deb", 32'(debounced), 32'h01);
    chk("bit0_accept_rise", 32'(rise), 32'h01);
    chk("bit0_accept_changed", 32'(changed), 32'h1);
    chk("bit0_accept_fall", 32'(fall), 32'h00);
    tick(1);
    chk("bit0_after_rise", 32'(rise), 32'h00);
    chk("bit0_after_changed", 32'(changed), 32'h0);
    drive(8'h00);
    tick(10);

    // Short pulse is filtered.
    ev0 = strobe_events;
    drive(8'h08); drive(8'h08); drive(8'h08); drive(8'h00);
    tick(12);
    chk("bit3_short_pulse_strobes", 32'(strobe_events - ev0), 32'd0);
    chk("bit3_short_pulse_deb", 32'(debounced), 32'h00);

    // Bounce train then steady high: single rise 4 cycles after s settles.
    ev0 = strobe_events;
    drive(8'h08); drive(8'h00); drive(8'h08); drive(8'h08); drive(8'h00);
    drive(8'h08);
    tick(5);
    chk("bit3_bounce_before", 32'(rise), 32'h00);
    tick(1);
    chk("bit3_bounce_rise", 32'(rise), 32'h08);
    chk("bit3_bounce_deb", 32'(debounced), 32'h08);
    tick(6);
    chk("bit3_bounce_single_strobe", 32'(strobe_events - ev0), 32'd1);
    drive(8'h00);
    tick(10);

    // Simultaneous acceptance on several bits.
    drive(8'hA5);
    tick(5);
    chk("multi_before_deb", 32'(debounced), 32'h00);
    tick(1);
    chk("multi_rise", 32'(rise), 32'hA5);
    chk("multi_deb", 32'(debounced), 32'hA5);
    chk("multi_changed", 32'(changed), 32'h1);
    tick(1);
    chk("multi_changed_one_cycle", 32'(changed), 32'h0);
    drive(8'h00);
    tick(6);
    chk("multi_fall", 32'(fall), 32'hA5);
    chk("multi_fall_deb", 32'(debounced), 32'h00);
    tick(4);

    // Reset while bit 2 is mid-count.
    drive(8'h04);
    tick(4);
    chk("bit2_cnt_mid", 32'(dut.g_chan[2].u_chan.cnt_q), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("bit2_reset_cnt", 32'(dut.g_chan[2].u_chan.cnt_q), 32'd0);
    chk("bit2_reset_deb", 32'(debounced), 32'h00);
    tick(2);
    @(negedge clk);
    reset_n = 1'b1;
    tick(5);
    chk("bit2_release_before", 32'(rise), 32'h00);
    tick(1);
    chk("bit2_release_rise", 32'(rise), 32'h04);
    chk("bit2_release_deb", 32'(debounced), 32'h04);
    drive(8'h00);
    tick(8);

    // All inputs high through reset: one rise on all bits 5 cycles after release.
    @(negedge clk);
    reset_n = 1'b0;
    raw_in  = 8'hFF;
    tick(2);
    @(negedge clk);
    reset_n = 1'b1;
    ev0 = strobe_events;
    tick(5);
    chk("ff_release_before", 32'(rise), 32'h00);
    tick(1);
    chk("ff_release_rise", 32'(rise), 32'hFF);
    tick(14);
    chk("ff_release_single_strobe", 32'(strobe_events - ev0), 32'd1);

    // Randomised bounce on all bits; the per-cycle model compare does the checking.
    for (int c = 0; c < 10000; c++) begin
      logic [W-1:0] v;
      v = raw_in;
      for (int b = 0; b < int'(W); b++) if ($urandom_range(0, 4) == 0) v[b] = ~v[b];
      drive(v);
    end
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
